// File: rtl/m2v_pkg.sv
// Shared types and helpers for the IDCT transposition buffer.
package m2v_pkg;

    typedef enum logic [0:0] {
        WS_IDLE = 1'b0,
        WS_FILL = 1'b1
    } wstate_t;

    localparam int BLK_SAMPLES = 64;

    // Row-major sample index held by lane 'lane' at read address 'addr'.
    function automatic logic [5:0] rd_index(input int unsigned addr, input int unsigned lane,
                                            input int unsigned npix);
        int unsigned pos;
        pos = addr * npix;
        return 6'((8 * ((pos % 8) + lane) + pos / 8) % 64);
    endfunction

endpackage

// File: rtl/m2v_tbuf_lane_ram.sv
// One lane of sample storage: single write port, registered read port with sync clear.
module m2v_tbuf_lane_ram #(
    parameter int IW  = 16,
    parameter int ADW = 6
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 we,
    input  logic [ADW-1:0]       waddr,
    input  logic signed [IW-1:0] wdata,
    input  logic                 re,
    input  logic [ADW-1:0]       raddr,
    output logic signed [IW-1:0] rdata
);
    localparam int DEPTH = 1 << ADW;

    logic signed [IW-1:0] mem_q [DEPTH];
    logic signed [IW-1:0] rdata_q, rdata_d;

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    // The read register holds while re is low so the output freezes with the bank.
    always_comb begin
        rdata_d = rdata_q;
        if (re) rdata_d = mem_q[raddr];
    end

    always_ff @(posedge clk) begin
        if (clr) rdata_q <= '0;
        else     rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/m2v_idct_tbuf.sv
// Multi-bank 8x8 transposition buffer: row-major in, column-major out, NPIX samples per read.
// Optional macro M2V_TBUF_SAT_EN: saturate output lanes to the signed OW range instead of wrapping.
module m2v_idct_tbuf
    import m2v_pkg::*;
#(
    parameter int IW    = 16,
    parameter int OW    = 9,
    parameter int NBANK = 2,
    parameter int NPIX  = 2,
    localparam int AW   = $clog2(64 / NPIX)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 softreset,
    output logic                 ready,
    input  logic                 blk_start,
    input  logic                 blk_coded,
    output logic                 wr_ready,
    input  logic                 wr_valid,
    input  logic signed [IW-1:0] wr_data,
    output logic                 rd_valid,
    output logic                 rd_coded,
    input  logic [AW-1:0]        rd_addr,
    output logic [NPIX*OW-1:0]   rd_data,
    input  logic                 rd_done,
    output logic                 ovf
);
    localparam int BW = $clog2(NBANK);
    localparam int CW = $clog2(NBANK + 1);

`ifdef M2V_TBUF_SAT_EN
    localparam logic signed [IW-1:0] SAT_MAX = IW'((1 << (OW - 1)) - 1);
    localparam logic signed [IW-1:0] SAT_MIN = IW'(-(1 << (OW - 1)));
`endif

    function automatic logic signed [OW-1:0] reduce(input logic signed [IW-1:0] s);
`ifdef M2V_TBUF_SAT_EN
        if (s > SAT_MAX) return SAT_MAX[OW-1:0];
        if (s < SAT_MIN) return SAT_MIN[OW-1:0];
`endif
        return s[OW-1:0];
    endfunction

    wstate_t          state_q, state_d;
    logic [5:0]       beat_q, beat_d;
    logic [BW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [NBANK-1:0] filled_q, filled_d, coded_q, coded_d;
    logic             ready_q, ready_d;
    logic             ovf_q, ovf_d;
    logic             rd_zero_q, rd_zero_d;

    logic             clr, accept, wr_fire, release_bank, rd_valid_w;
    int unsigned      wrow, wcol;
    logic [AW-1:0]    waddr;

    assign clr          = !reset_n || softreset;
    assign rd_valid_w   = filled_q[rptr_q];
    assign accept       = blk_start && ready_q;
    assign wr_fire      = (state_q == WS_FILL) && wr_valid;
    assign release_bank = rd_done && rd_valid_w;

    // Row r lives in lane r%NPIX; within a lane, words are ordered column-major.
    always_comb begin
        wrow  = 32'(beat_q[5:3]);
        wcol  = 32'(beat_q[2:0]);
        waddr = AW'(wcol * (8 / NPIX) + wrow / NPIX);
    end

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        filled_d  = filled_q;
        coded_d   = coded_q;
        ovf_d     = ovf_q;
        rd_zero_d = rd_zero_q;

        if (accept) begin
            if (blk_coded) begin
                state_d = WS_FILL;
                beat_d  = '0;
            end else begin
                filled_d[wptr_q] = 1'b1;
                coded_d[wptr_q]  = 1'b0;
                wptr_d           = wptr_q + 1'b1;
            end
        end

        if (wr_fire) begin
            beat_d = beat_q + 1'b1;
            if (beat_q == 6'(BLK_SAMPLES - 1)) begin
                state_d          = WS_IDLE;
                filled_d[wptr_q] = 1'b1;
                coded_d[wptr_q]  = 1'b1;
                wptr_d           = wptr_q + 1'b1;
            end
        end

        // The bank being released is always distinct from the one being filled.
        if (release_bank) begin
            filled_d[rptr_q] = 1'b0;
            rptr_d           = rptr_q + 1'b1;
        end

        cnt_d = cnt_q + CW'(accept) - CW'(release_bank);

        if ((blk_start && !ready_q) || (rd_done && !rd_valid_w)) ovf_d = 1'b1;

        ready_d = (cnt_d < CW'(NBANK)) && (state_d == WS_IDLE);

        if (rd_valid_w) rd_zero_d = !coded_q[rptr_q];
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= WS_IDLE;
            beat_q    <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            cnt_q     <= '0;
            filled_q  <= '0;
            coded_q   <= '0;
            ready_q   <= 1'b1;
            ovf_q     <= 1'b0;
            rd_zero_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            cnt_q     <= cnt_d;
            filled_q  <= filled_d;
            coded_q   <= coded_d;
            ready_q   <= ready_d;
            ovf_q     <= ovf_d;
            rd_zero_q <= rd_zero_d;
        end
    end

    for (genvar k = 0; k < NPIX; k++) begin : g_lane
        logic signed [IW-1:0] lane_rdata;
        logic                 lane_we;

        assign lane_we = wr_fire && (wrow % NPIX == k);

        m2v_tbuf_lane_ram #(
            .IW (IW),
            .ADW(BW + AW)
        ) u_ram (
            .clk  (clk),
            .clr  (clr),
            .we   (lane_we),
            .waddr({wptr_q, waddr}),
            .wdata(wr_data),
            .re   (rd_valid_w),
            .raddr({rptr_q, rd_addr}),
            .rdata(lane_rdata)
        );

        assign rd_data[k*OW +: OW] = rd_zero_q ? '0 : reduce(lane_rdata);
    end

    assign ready    = ready_q;
    assign wr_ready = (state_q == WS_FILL);
    assign rd_valid = rd_valid_w;
    assign rd_coded = rd_valid_w && coded_q[rptr_q];
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_m2v_idct_tbuf.sv
// Self-checking bench for m2v_idct_tbuf: a 2-bank/2-lane instance and a 4-bank/4-lane instance.
module tb_m2v_idct_tbuf;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A: NBANK=2, NPIX=2
    logic        a_softreset = 0, a_blk_start = 0, a_blk_coded = 0, a_wr_valid = 0, a_rd_done = 0;
    logic [15:0] a_wr_data = '0;
    logic [4:0]  a_rd_addr = '0;
    logic        a_ready, a_wr_ready, a_rd_valid, a_rd_coded, a_ovf;
    logic [17:0] a_rd_data;

    m2v_idct_tbuf #(.IW(16), .OW(9), .NBANK(2), .NPIX(2)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .softreset(a_softreset), .ready(a_ready),
        .blk_start(a_blk_start), .blk_coded(a_blk_coded), .wr_ready(a_wr_ready),
        .wr_valid(a_wr_valid), .wr_data(a_wr_data), .rd_valid(a_rd_valid),
        .rd_coded(a_rd_coded), .rd_addr(a_rd_addr), .rd_data(a_rd_data),
        .rd_done(a_rd_done), .ovf(a_ovf)
    );

    // Instance B: NBANK=4, NPIX=4
    logic        b_softreset = 0, b_blk_start = 0, b_blk_coded = 0, b_wr_valid = 0, b_rd_done = 0;
    logic [15:0] b_wr_data = '0;
    logic [3:0]  b_rd_addr = '0;
    logic        b_ready, b_wr_ready, b_rd_valid, b_rd_coded, b_ovf;
    logic [35:0] b_rd_data;

    m2v_idct_tbuf #(.IW(16), .OW(9), .NBANK(4), .NPIX(4)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .softreset(b_softreset), .ready(b_ready),
        .blk_start(b_blk_start), .blk_coded(b_blk_coded), .wr_ready(b_wr_ready),
        .wr_valid(b_wr_valid), .wr_data(b_wr_data), .rd_valid(b_rd_valid),
        .rd_coded(b_rd_coded), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
        .rd_done(b_rd_done), .ovf(b_ovf)
    );

    typedef struct {
        int addr;
        int l0;
        int l1;
    } vec_t;
    vec_t tbl[8];

    logic [17:0] a_sb[$];
    logic [35:0] b_sb[$];
    bit          a_satpat = 0;
    int          b_done_cnt = 0;

`ifdef M2V_TBUF_SAT_EN
    localparam logic [8:0] EXP_P300 = 9'h0FF;
    localparam logic [8:0] EXP_M300 = 9'h100;
`else
    localparam logic [8:0] EXP_P300 = 9'h12C;
    localparam logic [8:0] EXP_M300 = 9'h0D4;
`endif

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [8:0] red(input int s);
`ifdef M2V_TBUF_SAT_EN
        if (s > 255) return 9'h0FF;
        if (s < -256) return 9'h100;
`endif
        return 9'(s);
    endfunction

    function automatic int a_samp(input int base, input int i);
        if (a_satpat && i == 0) return 300;
        if (a_satpat && i == 1) return -300;
        return base + i;
    endfunction

    function automatic logic [17:0] a_exp(input int base, input int a, input bit coded);
        logic [17:0] e;
        int idx;
        e = '0;
        for (int k = 0; k < 2; k++) begin
            idx = 8 * ((a * 2) % 8 + k) + (a * 2) / 8;
            if (coded) e[k*9 +: 9] = red(a_samp(base, idx));
        end
        return e;
    endfunction

    task automatic a_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic b_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic a_start(input bit coded);
        a_blk_start = 1;
        a_blk_coded = coded;
        a_cyc();
        a_blk_start = 0;
        a_blk_coded = 0;
    endtask

    task automatic a_done();
        a_rd_done = 1;
        a_cyc();
        a_rd_done = 0;
    endtask

    task automatic a_fill(input int base, input int first, input int last);
        int w;
        for (int i = first; i <= last; i++) begin
            w = 0;
            while (!a_wr_ready && w < 8) begin
                a_cyc();
                w++;
            end
            if (!a_wr_ready) begin
                a_wr_valid = 0;
                chk("a_fill_wr_ready_timeout", 64'(a_wr_ready), 64'(1));
                return;
            end
            a_wr_valid = 1;
            a_wr_data  = 16'(a_samp(base, i));
            a_cyc();
        end
        a_wr_valid = 0;
    endtask

    task automatic a_pop(input string nm);
        if (a_sb.size() == 0) chk({nm, "_sb_empty"}, 64'(a_sb.size()), 64'(1));
        else chk(nm, 64'(a_rd_data), 64'(a_sb.pop_front()));
    endtask

    task automatic a_read_all(input int base, input bit coded);
        for (int a = 0; a < 32; a++) begin
            a_rd_addr = 5'(a);
            a_sb.push_back(a_exp(base, a, coded));
            a_cyc();
            a_pop($sformatf("a_read base%0d addr%0d", base, a));
        end
    endtask

    task automatic b_writer();
        int w;
        for (int n = 0; n < 10; n++) begin
            w = 0;
            while (!b_ready && w < 3000) begin
                b_cyc();
                w++;
            end
            if (!b_ready) begin
                chk("b_ready_timeout", 64'(b_ready), 64'(1));
                return;
            end
            b_blk_start = 1;
            b_blk_coded = 1;
            b_cyc();
            b_blk_start = 0;
            b_blk_coded = 0;
            for (int i = 0; i < 64; i++) begin
                w = 0;
                while (!b_wr_ready && w < 8) begin
                    b_cyc();
                    w++;
                end
                if (!b_wr_ready) begin
                    b_wr_valid = 0;
                    chk("b_wr_ready_timeout", 64'(b_wr_ready), 64'(1));
                    return;
                end
                b_wr_valid = 1;
                b_wr_data  = 16'(i + 100 * n);
                b_cyc();
            end
            b_wr_valid = 0;
            b_done_cnt = n + 1;
        end
    endtask

    task automatic b_reader();
        int w;
        int idx;
        logic [35:0] e;
        repeat (300) b_cyc();
        for (int n = 0; n < 10; n++) begin
            w = 0;
            while (!b_rd_valid && w < 3000) begin
                b_cyc();
                w++;
            end
            if (!b_rd_valid) begin
                chk("b_rd_valid_timeout", 64'(b_rd_valid), 64'(1));
                return;
            end
            chk($sformatf("b_rd_coded blk%0d", n), 64'(b_rd_coded), 64'(1));
            for (int a = 0; a < 16; a++) begin
                b_rd_addr = 4'(a);
                e = '0;
                for (int k = 0; k < 4; k++) begin
                    idx = 8 * ((a * 4) % 8 + k) + (a * 4) / 8;
                    e[k*9 +: 9] = red(idx + 100 * n);
                end
                b_sb.push_back(e);
                b_cyc();
                chk($sformatf("b_rd_valid_hold blk%0d addr%0d", n, a), 64'(b_rd_valid), 64'(1));
                if (b_sb.size() == 0) chk("b_sb_empty", 64'(b_sb.size()), 64'(1));
                else chk($sformatf("b_read blk%0d addr%0d", n, a), 64'(b_rd_data), 64'(b_sb.pop_front()));
            end
            b_rd_done = 1;
            b_cyc();
            b_rd_done = 0;
            #1;
            if (b_done_cnt > n + 1)
                chk($sformatf("b_valid_cont blk%0d", n), 64'(b_rd_valid), 64'(1));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{0, 0, 8};
        tbl[1] = '{1, 16, 24};
        tbl[2] = '{4, 1, 9};
        tbl[3] = '{3, 48, 56};
        tbl[4] = '{5, 17, 25};
        tbl[5] = '{16, 4, 12};
        tbl[6] = '{31, 55, 63};
        tbl[7] = '{0, 0, 8};

        // Reset
        reset_n = 0;
        repeat (3) a_cyc();
        chk("rst_ready", 64'(a_ready), 64'(1));
        reset_n = 1;
        a_cyc();
        chk("rst_ready_after", 64'(a_ready), 64'(1));
        chk("rst_wr_ready", 64'(a_wr_ready), 64'(0));
        chk("rst_rd_valid", 64'(a_rd_valid), 64'(0));
        chk("rst_rd_coded", 64'(a_rd_coded), 64'(0));
        chk("rst_rd_data", 64'(a_rd_data), 64'(0));
        chk("rst_ovf", 64'(a_ovf), 64'(0));

        // Sequential coded block, last-beat latency, table-driven transposed reads
        a_start(1);
        chk("seq_wr_ready", 64'(a_wr_ready), 64'(1));
        chk("seq_ready_fill", 64'(a_ready), 64'(0));
        a_fill(0, 0, 62);
        a_wr_valid = 1;
        a_wr_data  = 16'd63;
        chk("seq_valid_before_last", 64'(a_rd_valid), 64'(0));
        a_cyc();
        a_wr_valid = 0;
        chk("seq_valid_after_last", 64'(a_rd_valid), 64'(1));
        chk("seq_wr_ready_drop", 64'(a_wr_ready), 64'(0));
        chk("seq_ready_back", 64'(a_ready), 64'(1));
        chk("seq_rd_coded", 64'(a_rd_coded), 64'(1));
        for (int v = 0; v < 8; v++) begin
            a_rd_addr = 5'(tbl[v].addr);
            a_sb.push_back({9'(tbl[v].l1), 9'(tbl[v].l0)});
            a_cyc();
            a_pop($sformatf("seq_tbl addr%0d", tbl[v].addr));
        end
        a_done();
        chk("seq_released", 64'(a_rd_valid), 64'(0));
        chk("seq_ovf", 64'(a_ovf), 64'(0));

        // Uncoded block
        a_start(0);
        chk("unc_rd_valid", 64'(a_rd_valid), 64'(1));
        chk("unc_rd_coded", 64'(a_rd_coded), 64'(0));
        chk("unc_wr_ready", 64'(a_wr_ready), 64'(0));
        a_read_all(0, 0);
        chk("unc_wr_ready_end", 64'(a_wr_ready), 64'(0));
        a_done();

        // Back-to-back fill, overflow, simultaneous start/done when full
        a_start(1);
        a_fill(200, 0, 63);
        chk("b2b_ready_one", 64'(a_ready), 64'(1));
        a_start(1);
        a_fill(300, 0, 63);
        chk("b2b_ready_full", 64'(a_ready), 64'(0));
        chk("b2b_ovf_clear", 64'(a_ovf), 64'(0));
        a_start(1);
        chk("b2b_ovf_set", 64'(a_ovf), 64'(1));
        chk("b2b_refused", 64'(a_wr_ready), 64'(0));
        a_blk_start = 1;
        a_blk_coded = 1;
        a_rd_done   = 1;
        a_cyc();
        a_blk_start = 0;
        a_blk_coded = 0;
        a_rd_done   = 0;
        chk("b2b_same_cycle_refused", 64'(a_wr_ready), 64'(0));
        chk("b2b_ready_after_done", 64'(a_ready), 64'(1));
        chk("b2b_next_valid", 64'(a_rd_valid), 64'(1));
        a_start(1);
        chk("b2b_third_accepted", 64'(a_wr_ready), 64'(1));
        a_fill(400, 0, 63);
        a_read_all(300, 1);
        a_done();
        chk("b2b_valid_third", 64'(a_rd_valid), 64'(1));
        a_read_all(400, 1);
        a_done();
        chk("b2b_empty", 64'(a_rd_valid), 64'(0));

        // Output reduction of out-of-range samples
        a_satpat = 1;
        a_start(1);
        a_fill(0, 0, 63);
        a_rd_addr = 5'd0;
        a_cyc();
        chk("sat_p300", 64'(a_rd_data[8:0]), 64'(EXP_P300));
        a_rd_addr = 5'd4;
        a_cyc();
        chk("sat_m300", 64'(a_rd_data[8:0]), 64'(EXP_M300));
        a_read_all(0, 1);
        a_done();
        a_satpat = 0;

        // Softreset mid-fill with one bank queued
        chk("ovf_sticky", 64'(a_ovf), 64'(1));
        a_start(1);
        a_fill(600, 0, 63);
        a_start(1);
        a_fill(700, 0, 30);
        a_softreset = 1;
        a_cyc();
        a_softreset = 0;
        chk("srst_ready", 64'(a_ready), 64'(1));
        chk("srst_rd_valid", 64'(a_rd_valid), 64'(0));
        chk("srst_ovf", 64'(a_ovf), 64'(0));
        chk("srst_wr_ready", 64'(a_wr_ready), 64'(0));
        chk("srst_rd_data", 64'(a_rd_data), 64'(0));
        a_wr_valid = 1;
        a_wr_data  = 16'h1234;
        repeat (4) a_cyc();
        a_wr_valid = 0;
        chk("idle_wr_no_ovf", 64'(a_ovf), 64'(0));
        chk("idle_wr_no_valid", 64'(a_rd_valid), 64'(0));
        a_start(1);
        a_fill(800, 0, 63);
        a_read_all(800, 1);
        a_done();
        a_done();
        chk("done_empty_ovf", 64'(a_ovf), 64'(1));

        // Streaming wrap-around on the 4-bank, 4-lane instance
        fork
            b_writer();
            b_reader();
        join
        chk("b_ovf", 64'(b_ovf), 64'(0));
        chk("b_drained", 64'(b_rd_valid), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
